ps_shift_register: RTL and testbench

//  - Parallel-load / serial-shift register (PISO with serial-in and parallel tap).
//  - Loads a WIDTH-bit word in one clock, then shifts it out MSB-first on sout, one bit per clock.
//  - Shifts sin into the LSB on every shift.
//  - Used as a serializer front end.
//  - qout exposes the full register for debug and for SIPO use.

---
 rtl/ps_shift_register_pkg.sv | 7 +
 rtl/ps_shift_register_cell.sv | 31 +++
 rtl/ps_shift_register.sv | 43 ++++
 tb/tb_ps_shift_register.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ps_shift_register_pkg.sv
// Shared defaults for the parallel-load / serial-shift register.
package ps_shift_register_pkg;

   localparam int                         DEFAULT_WIDTH   = 8;
   localparam logic [DEFAULT_WIDTH-1:0]   DEFAULT_RST_VAL = '0;

endpackage : ps_shift_register_pkg

// File: rtl/ps_shift_register_cell.sv
// One bit of the shift register: a load/shift 2:1 mux in front of a flop
// with asynchronous active-low reset.
module ps_shift_cell #(
   parameter logic RST_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic din_i,
   input  logic prev_bit,
   output logic q_o
);

   logic bit_d;
   logic bit_q;

   always_comb begin
      bit_d = load ? din_i : prev_bit;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_q <= RST_BIT;
      end else begin
         bit_q <= bit_d;
      end
   end

   assign q_o = bit_q;

endmodule : ps_shift_cell

// File: rtl/ps_shift_register.sv
// Parallel-load, MSB-first serial-shift register with serial input and
// a full parallel tap; built from WIDTH single-bit cells.
module ps_shift_register
   import ps_shift_register_pkg::*;
#(
   parameter int               WIDTH   = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             sin,
   output logic             sout,
   output logic [WIDTH-1:0] qout
);

   // The MSB-out shift needs at least one bit of history besides the output.
   if (WIDTH < 2) begin : g_width_check
      $error("ps_shift_register: WIDTH must be >= 2");
   end

   logic [WIDTH-1:0] prev_bits;

   // Each cell takes its neighbour below; bit 0 takes the serial input.
   assign prev_bits = {qout[WIDTH-2:0], sin};

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ps_shift_cell #(
         .RST_BIT (RST_VAL[i])
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .load     (load),
         .din_i    (din[i]),
         .prev_bit (prev_bits[i]),
         .q_o      (qout[i])
      );
   end

   assign sout = qout[WIDTH-1];

endmodule : ps_shift_register

// File: tb/tb_ps_shift_register.sv
// Directed table-driven bench for ps_shift_register (WIDTH=8, RST_VAL=0).
module tb_ps_shift_register;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         load;
   logic [W-1:0] din;
   logic         sin;
   logic         sout;
   logic [W-1:0] qout;

   int n_checks;
   int n_errors;

   typedef struct {
      logic         load;
      logic [W-1:0] din;
      logic         sin;
      logic [W-1:0] exp_q;
      logic         exp_s;
   } vec_t;

   vec_t vecs[$];

   ps_shift_register #(
      .WIDTH   (W),
      .RST_VAL ('0)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .din  (din),
      .sin  (sin),
      .sout (sout),
      .qout (qout)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic check(input string nm, input logic [W-1:0] act_q, input logic act_s,
                        input logic [W-1:0] exp_q, input logic exp_s);
      n_checks++;
      if (act_q !== exp_q || act_s !== exp_s) begin
         n_errors++;
         $display("FAIL %s: qout=%h sout=%b, required qout=%h sout=%b",
                  nm, act_q, act_s, exp_q, exp_s);
      end
   endtask

   task automatic add(input logic l, input logic [W-1:0] d, input logic s,
                      input logic [W-1:0] eq, input logic es);
      vec_t v;
      v.load = l; v.din = d; v.sin = s; v.exp_q = eq; v.exp_s = es;
      vecs.push_back(v);
   endtask

   // Drive on the falling edge, apply one rising edge, sample 1 ns later.
   task automatic step(input logic l, input logic [W-1:0] d, input logic s);
      @(negedge clk);
      load = l; din = d; sin = s;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst  = 1'b1;
      load = 1'b0;
      din  = '0;
      sin  = 1'b0;

      // Main load/shift scenario
      add(1, 8'hBB, 0, 8'hBB, 1);
      add(0, 8'h00, 0, 8'h76, 0);
      add(0, 8'h00, 0, 8'hEC, 1);
      add(0, 8'h00, 0, 8'hD8, 1);
      add(0, 8'h00, 0, 8'hB0, 1);
      add(0, 8'h00, 0, 8'h60, 0);
      add(0, 8'h00, 0, 8'hC0, 1);
      add(0, 8'h00, 0, 8'h80, 1);
      add(0, 8'h00, 0, 8'h00, 0);
      // Serial-in fill with ones
      add(0, 8'h00, 1, 8'h01, 0);
      add(0, 8'h00, 1, 8'h03, 0);
      add(0, 8'h00, 1, 8'h07, 0);
      add(0, 8'h00, 1, 8'h0F, 0);
      add(0, 8'h00, 1, 8'h1F, 0);
      add(0, 8'h00, 1, 8'h3F, 0);
      add(0, 8'h00, 1, 8'h7F, 0);
      add(0, 8'h00, 1, 8'hFF, 1);
      // Load beats shift, sin ignored
      add(1, 8'h5A, 1, 8'h5A, 0);
      // Reload mid-shift
      add(1, 8'hF0, 0, 8'hF0, 1);
      add(0, 8'h00, 0, 8'hE0, 1);
      add(0, 8'h00, 0, 8'hC0, 1);
      add(0, 8'h00, 0, 8'h80, 1);
      add(1, 8'h0F, 1, 8'h0F, 0);
      // Drain to zero and stay there
      add(0, 8'hAA, 0, 8'h1E, 0);
      add(0, 8'hAA, 0, 8'h3C, 0);
      add(0, 8'hAA, 0, 8'h78, 0);
      add(0, 8'hAA, 0, 8'hF0, 1);
      add(0, 8'hAA, 0, 8'hE0, 1);
      add(0, 8'hAA, 0, 8'hC0, 1);
      add(0, 8'hAA, 0, 8'h80, 1);
      add(0, 8'hAA, 0, 8'h00, 0);
      add(0, 8'hAA, 0, 8'h00, 0);

      // Async reset asserted mid-cycle, before any rising edge
      #20;
      rst = 1'b0;
      #1;
      check("async_reset", qout, sout, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      check("reset_held", qout, sout, 8'h00, 1'b0);

      // Release on a falling edge; the very next rising edge is live
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].load, vecs[i].din, vecs[i].sin);
         check($sformatf("vec%0d", i), qout, sout, vecs[i].exp_q, vecs[i].exp_s);
      end

      // Reset mid-shift: contents lost without a clock edge
      step(1, 8'hFF, 0);
      check("rs_load", qout, sout, 8'hFF, 1'b1);
      step(0, 8'h00, 0);
      step(0, 8'h00, 0);
      check("rs_shift2", qout, sout, 8'hFC, 1'b1);
      @(negedge clk);
      #10;
      rst = 1'b0;
      #1;
      check("rs_async", qout, sout, 8'h00, 1'b0);
      load = 1'b1; din = 8'hAA; sin = 1'b1;
      @(posedge clk);
      #1;
      check("rs_load_blocked", qout, sout, 8'h00, 1'b0);

      // Release with load pending: first edge after release loads
      @(negedge clk);
      rst = 1'b1;
      din = 8'h3C;
      @(posedge clk);
      #1;
      check("release_load", qout, sout, 8'h3C, 1'b0);

      // Input glitch between edges has no effect
      @(negedge clk);
      load = 1'b0; sin = 1'b0;
      #10 load = 1'b1; din = 8'hFF;
      #10 load = 1'b0; din = 8'h00;
      @(posedge clk);
      #1;
      check("glitch", qout, sout, 8'h78, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_ps_shift_register
